// File: rtl/fetch_bus_sequencer.sv
// fetch_bus_sequencer
//
// Decides which requester owns the shared 8-bit memory bus: instruction
// fetch (stage 0), the load/store data stage, or an external DMA master.
// It drives stage 0's busRequest/fetchSuppress pins and flushes the fetch
// latch after a taken branch.
//
// Ports
//   clk            in   system clock, rising edge
//   reset          in   asynchronous active-high reset
//   dma_req        in   DMA master wants the bus (held level)
//   data_req       in   load/store stage wants a data access
//   data_two       in   sampled in DATA1: 1 = two-cycle (16-bit) access
//   branch_taken   in   one-cycle pulse, taken branch resolved
//   halt           in   HLT executing, park fetch
//   bus_request    out  fetch does not own the bus (stage 0 busRequest)
//   fetch_suppress out  fetch latch bubbles (stage 0 fetchSuppress)
//   fetch_en       out  fetch owns the bus, PC may increment
//   data_grant     out  data stage owns the bus
//   dma_grant      out  DMA master owns the bus
//   state_dbg      out  registered state code
//
// Handshake: requests are levels sampled on every rising edge; a grant is a
// Moore decode of the registered state, so it is stable for the whole cycle
// and never depends combinationally on a request.

module fetch_bus_sequencer #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned DMA_MAX      = 8,
    parameter int unsigned CNT_W        = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       dma_req,
    input  logic       data_req,
    input  logic       data_two,
    input  logic       branch_taken,
    input  logic       halt,
    output logic       bus_request,
    output logic       fetch_suppress,
    output logic       fetch_en,
    output logic       data_grant,
    output logic       dma_grant,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_DATA1 = 3'd1,
        S_DATA2 = 3'd2,
        S_DMA   = 3'd3,
        S_FLUSH = 3'd4,
        S_HALT  = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] DMA_LAST   = CNT_W'(DMA_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0] dma_cnt_q, dma_cnt_d;
    logic             dma_block_q, dma_block_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_FETCH;
            flush_cnt_q <= '0;
            dma_cnt_q   <= '0;
            dma_block_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            dma_cnt_q   <= dma_cnt_d;
            dma_block_q <= dma_block_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        dma_cnt_d   = dma_cnt_q;
        dma_block_d = dma_block_q;

        case (state_q)
            S_FETCH: begin
                // The fetch cycle that follows a maxed-out DMA tenure is the
                // forced fetch; dma_block only lets a branch, data access or
                // halt win over DMA on that one decision. With nothing else
                // pending, DMA resumes straight after the single fetch cycle.
                dma_block_d = 1'b0;
                if (branch_taken) begin
                    state_d     = S_FLUSH;
                    flush_cnt_d = FLUSH_LOAD;
                end else if (dma_req && !dma_block_q) begin
                    state_d   = S_DMA;
                    dma_cnt_d = '0;
                end else if (data_req) begin
                    state_d = S_DATA1;
                end else if (halt) begin
                    state_d = S_HALT;
                end else if (dma_req) begin
                    state_d   = S_DMA;
                    dma_cnt_d = '0;
                end
            end
            S_DATA1: begin
                // Data accesses run to completion; nothing preempts them.
                state_d = data_two ? S_DATA2 : S_FETCH;
            end
            S_DATA2: begin
                state_d = S_FETCH;
            end
            S_DMA: begin
                if (!dma_req) begin
                    state_d = S_FETCH;
                end else if (dma_cnt_q == DMA_LAST) begin
                    state_d     = S_FETCH;
                    dma_block_d = 1'b1;
                end else begin
                    dma_cnt_d = dma_cnt_q + CNT_ONE;
                end
            end
            S_FLUSH: begin
                // A new branch restarts the bubble so suppress always spans
                // FLUSH_CYCLES after the last branch.
                if (branch_taken) begin
                    flush_cnt_d = FLUSH_LOAD;
                end else if (flush_cnt_q == '0) begin
                    state_d = S_FETCH;
                end else begin
                    flush_cnt_d = flush_cnt_q - CNT_ONE;
                end
            end
            S_HALT: begin
                // DMA is served while parked; the way back is through FETCH,
                // which re-parks if halt is still high.
                if (dma_req) begin
                    state_d   = S_DMA;
                    dma_cnt_d = '0;
                end else if (!halt) begin
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    assign fetch_en       = (state_q == S_FETCH);
    assign data_grant     = (state_q == S_DATA1) || (state_q == S_DATA2);
    assign dma_grant      = (state_q == S_DMA);
    assign fetch_suppress = (state_q == S_FLUSH);
    assign bus_request    = (state_q == S_DATA1) || (state_q == S_DATA2) ||
                            (state_q == S_DMA)   || (state_q == S_HALT);
    assign state_dbg      = state_q;

endmodule

// File: tb/tb_fetch_bus_sequencer.sv
module tb_fetch_bus_sequencer;

  localparam logic [2:0] FETCH = 3'd0;
  localparam logic [2:0] DATA1 = 3'd1;
  localparam logic [2:0] DATA2 = 3'd2;
  localparam logic [2:0] DMA   = 3'd3;
  localparam logic [2:0] FLUSH = 3'd4;
  localparam logic [2:0] HALT  = 3'd5;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       dma_req = 1'b0;
  logic       data_req = 1'b0;
  logic       data_two = 1'b0;
  logic       branch_taken = 1'b0;
  logic       halt = 1'b0;
  logic       bus_request;
  logic       fetch_suppress;
  logic       fetch_en;
  logic       data_grant;
  logic       dma_grant;
  logic [2:0] state_dbg;

  logic [7:0] exp_q[$];
  int         vectors = 0;
  int         miscompares = 0;

  fetch_bus_sequencer dut (
    .clk(clk),
    .reset(reset),
    .dma_req(dma_req),
    .data_req(data_req),
    .data_two(data_two),
    .branch_taken(branch_taken),
    .halt(halt),
    .bus_request(bus_request),
    .fetch_suppress(fetch_suppress),
    .fetch_en(fetch_en),
    .data_grant(data_grant),
    .dma_grant(dma_grant),
    .state_dbg(state_dbg)
  );

  // clock
  always #5 clk = ~clk;

  // Expected output vector for a given state, from the output decode table.
  function automatic logic [7:0] exp_vec(input logic [2:0] s);
    logic br, sup, fen, dg, dmag;
    br   = (s == DATA1) || (s == DATA2) || (s == DMA) || (s == HALT);
    sup  = (s == FLUSH);
    fen  = (s == FETCH);
    dg   = (s == DATA1) || (s == DATA2);
    dmag = (s == DMA);
    return {s, br, sup, fen, dg, dmag};
  endfunction

  // scoreboard compare: pop one expectation and check all outputs
  task automatic check(input string tag);
    logic [7:0] obs;
    logic [7:0] exp;
    obs = {state_dbg, bus_request, fetch_suppress, fetch_en, data_grant, dma_grant};
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL %s: scoreboard empty, observed %h", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      vectors++;
      assert (obs === exp) else begin
        miscompares++;
        $error("FAIL %s: observed {st,breq,sup,fen,dg,dmag}=%h expected %h", tag, obs, exp);
      end
    end
  endtask

  // driver: apply inputs for one clock, push the expected post-edge state
  task automatic step(input logic d, input logic da, input logic two,
                      input logic b, input logic h, input logic [2:0] s,
                      input string tag);
    dma_req      = d;
    data_req     = da;
    data_two     = two;
    branch_taken = b;
    halt         = h;
    exp_q.push_back(exp_vec(s));
    @(posedge clk);
    #1;
    check(tag);
  endtask

  initial begin
    // reset block
    #1;
    exp_q.push_back(exp_vec(FETCH));
    check("reset_held");
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // idle after reset release
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, FETCH, "idle");

    // single branch: two suppress cycles
    step(0, 0, 0, 1, 0, FLUSH, "br1_f0");
    step(0, 0, 0, 0, 0, FLUSH, "br1_f1");
    step(0, 0, 0, 0, 0, FETCH, "br1_done");

    // second branch in first flush cycle: three suppress cycles
    step(0, 0, 0, 1, 0, FLUSH, "br2_f0");
    step(0, 0, 0, 1, 0, FLUSH, "br2_f1");
    step(0, 0, 0, 0, 0, FLUSH, "br2_f2");
    step(0, 0, 0, 0, 0, FETCH, "br2_done");

    // 16-bit access with DMA raised during DATA1
    step(0, 1, 0, 0, 0, DATA1, "d2_data1");
    step(1, 0, 1, 1, 0, DATA2, "d2_data2");
    step(1, 0, 0, 1, 0, FETCH, "d2_fetch");
    step(1, 0, 0, 0, 0, DMA,   "d2_dma");
    step(0, 0, 0, 0, 0, FETCH, "d2_dma_end");

    // 8-bit access
    step(0, 1, 0, 0, 0, DATA1, "d1_data1");
    step(0, 0, 0, 0, 0, FETCH, "d1_fetch");

    // DMA held 20 clocks: 8 DMA, 1 FETCH, 8 DMA, 1 FETCH, 2 DMA
    for (int i = 0; i < 8; i++) step(1, 0, 0, 0, 0, DMA, "dma20_a");
    step(1, 0, 0, 0, 0, FETCH, "dma20_forced1");
    for (int i = 0; i < 8; i++) step(1, 0, 0, 0, 0, DMA, "dma20_b");
    step(1, 0, 0, 0, 0, FETCH, "dma20_forced2");
    for (int i = 0; i < 2; i++) step(1, 0, 0, 0, 0, DMA, "dma20_c");
    step(0, 0, 0, 0, 0, FETCH, "dma20_end");

    // DMA and data together: DMA wins when not blocked
    step(1, 1, 0, 0, 0, DMA,   "dd_dma_wins");
    step(0, 1, 0, 0, 0, FETCH, "dd_dma_end");
    step(0, 1, 0, 0, 0, DATA1, "dd_data1");
    step(0, 0, 0, 0, 0, FETCH, "dd_fetch");

    // data wins on the forced fetch decision after a full DMA tenure
    for (int i = 0; i < 8; i++) step(1, 0, 0, 0, 0, DMA, "blk_dma");
    step(1, 0, 0, 0, 0, FETCH, "blk_forced");
    step(1, 1, 0, 0, 0, DATA1, "blk_data_wins");
    step(1, 0, 0, 0, 0, FETCH, "blk_fetch");
    step(1, 0, 0, 0, 0, DMA,   "blk_dma_again");
    step(0, 0, 0, 0, 0, FETCH, "blk_end");

    // halt with a 3-clock DMA pulse
    step(0, 0, 0, 0, 1, HALT,  "h_enter");
    step(1, 0, 0, 0, 1, DMA,   "h_dma0");
    step(1, 0, 0, 0, 1, DMA,   "h_dma1");
    step(1, 0, 0, 0, 1, DMA,   "h_dma2");
    step(0, 0, 0, 0, 1, FETCH, "h_fetch");
    step(0, 0, 0, 0, 1, HALT,  "h_reenter");
    step(0, 0, 0, 1, 1, HALT,  "h_branch_ignored");
    step(0, 0, 0, 0, 0, FETCH, "h_release");

    // branch, DMA and data together: flush, then DMA, then data
    step(1, 1, 0, 1, 0, FLUSH, "all_f0");
    step(1, 1, 0, 0, 0, FLUSH, "all_f1");
    step(1, 1, 0, 0, 0, FETCH, "all_fetch");
    step(1, 1, 0, 0, 0, DMA,   "all_dma");
    step(0, 1, 0, 0, 0, FETCH, "all_dma_end");
    step(0, 1, 0, 0, 0, DATA1, "all_data1");
    step(0, 0, 0, 0, 0, FETCH, "all_fetch2");

    // asynchronous reset mid-DMA
    step(1, 0, 0, 0, 0, DMA, "rst_dma0");
    step(1, 0, 0, 0, 0, DMA, "rst_dma1");
    #2;
    reset = 1'b1;
    #1;
    exp_q.push_back(exp_vec(FETCH));
    check("rst_mid_dma");
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(0, 0, 0, 0, 0, FETCH, "rst_dma_after");

    // asynchronous reset mid-DATA2
    step(0, 1, 0, 0, 0, DATA1, "rst_data1");
    step(0, 0, 1, 0, 0, DATA2, "rst_data2");
    #2;
    reset = 1'b1;
    #1;
    exp_q.push_back(exp_vec(FETCH));
    check("rst_mid_data2");
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(0, 0, 0, 0, 0, FETCH, "rst_data_after");

    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d left, 0 required", exp_q.size());
    end

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_bus_sequencer.md
Name: fetch_bus_sequencer

Overview:
- Controls ownership of the single 8-bit memory bus shared by three requesters: instruction fetch (pipeline stage 0), data access (load/store stage) and an external DMA master.
- Drives stage 0's busRequest and fetchSuppress inputs.
- Flushes the fetch latch for a fixed number of cycles after a taken branch.
- Bounds DMA tenure so fetch cannot starve.

Parameters:
- FLUSH_CYCLES, 2: cycles fetch_suppress stays high after a taken branch (1..15).
- DMA_MAX, 8: maximum consecutive DMA-owned cycles before one forced fetch cycle (1..15).
- CNT_W, 4: width of the internal flush and DMA counters.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- dma_req  in  1  external master requests the bus; level held until it is done.
- data_req  in  1  load/store stage requests a data access.
- data_two  in  1  sampled in DATA1; high means a 2-cycle (16-bit) access.
- branch_taken  in  1  1-cycle pulse; taken branch resolved.
- halt  in  1  HLT executing; park the fetch unit.
- bus_request  out  1  to stage 0 busRequest; fetch does not own the bus.
- fetch_suppress  out  1  to stage 0 fetchSuppress; latch bubbles.
- fetch_en  out  1  fetch owns the bus; PC increment allowed.
- data_grant  out  1  data stage owns the bus.
- dma_grant  out  1  DMA master owns the bus.
- state_dbg  out  3  current state encoding.

Behaviour:
- State encoding: FETCH=0, DATA1=1, DATA2=2, DMA=3, FLUSH=4, HALT=5. Codes 6 and 7 recover to FETCH on the next clock.
- All outputs are a Moore decode of the registered state, glitch-free and settled before the negedge on which stage 0 latches.
  - fetch_en = FETCH
  - data_grant = DATA1 | DATA2
  - dma_grant = DMA
  - fetch_suppress = FLUSH
  - bus_request = DATA1 | DATA2 | DMA | HALT
- Exactly one of fetch_en, data_grant, dma_grant, fetch_suppress, or HALT is active at any time.
- Reset (asynchronous, immediate):
  - state=FETCH, flush_cnt=0, dma_cnt=0, dma_block=0.
  - Outputs: fetch_en=1, all other outputs 0, state_dbg=0.
  - Reset asserted mid-DMA or mid-DATA2 aborts the transaction with no completion cycle.
- FETCH, priority order (first match wins):
  - branch_taken -> FLUSH, flush_cnt=FLUSH_CYCLES-1.
  - dma_req & !dma_block -> DMA, dma_cnt=0.
  - data_req -> DATA1.
  - halt -> HALT.
  - Otherwise stay in FETCH.
  - Any cycle spent in FETCH clears dma_block.
- DATA1: data_two=1 -> DATA2; otherwise -> FETCH. A data access is never preempted, including by DMA or branch.
- DATA2: -> FETCH unconditionally.
- DMA:
  - dma_req=0 -> FETCH.
  - Else if dma_cnt==DMA_MAX-1 -> FETCH and set dma_block=1.
  - Else stay and increment dma_cnt.
  - Latency from dma_req rising in FETCH to dma_grant is 1 clock.
- FLUSH:
  - branch_taken reloads flush_cnt=FLUSH_CYCLES-1 and stays.
  - Else if flush_cnt==0 -> FETCH.
  - Else decrement flush_cnt.
  - dma_req and data_req wait.
  - Total suppress length after the last branch is FLUSH_CYCLES cycles.
- HALT:
  - dma_req -> DMA. Return path goes via FETCH, which re-enters HALT if halt is still high.
  - halt=0 -> FETCH.
  - branch_taken is ignored.
- Simultaneous events:
  - branch_taken with dma_req in FETCH: branch wins; DMA is granted after the flush.
  - data_req with dma_req: DMA wins unless dma_block=1.
- Counters saturate-free within CNT_W. Parameter values outside 1..(2^CNT_W-1) are illegal.

Test Plan:
- Reset release, no requests -> fetch_en=1, bus_request=0, state_dbg=0 on every clock; assert reset mid-DMA -> dma_grant=0, fetch_en=1 immediately.
- branch_taken pulse in FETCH, FLUSH_CYCLES=2 -> fetch_suppress=1 for exactly 2 clocks, then fetch_en=1; a second pulse in the first FLUSH cycle extends suppress to 3 clocks total.
- data_req with data_two=1 -> data_grant and bus_request high for 2 clocks, then FETCH; dma_req raised during DATA1 -> dma_grant only after DATA2 and one FETCH evaluation.
- dma_req held high for 20 clocks, DMA_MAX=8 -> grant pattern 8 DMA, 1 FETCH, 8 DMA, 1 FETCH, 2 DMA; bus_request low only in the FETCH cycles.
- halt=1 in FETCH -> HALT (bus_request=1, fetch_en=0); dma_req pulse for 3 clocks -> DMA 3 clocks, FETCH 1 clock, back to HALT; halt=0 -> FETCH.
- branch_taken, dma_req and data_req all high in FETCH -> FLUSH first, then DMA, then DATA1 after dma_req drops.
